// File: rtl/instruction_fetch.sv
// Instruction fetch stage: sequential PC generation, an in-order instruction
// memory request/response handshake with at most two requests in flight, a
// 2-entry {pc, instr} skid FIFO, a bypass path into the decode-facing output
// registers, and redirect handling that discards responses still in flight.
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   -> a redirect to a non-word-aligned target raises fetch_misalign
//                and parks the stage in HALT until the next aligned redirect.
//   undefined -> redirect_pc[1:0] is ignored and fetch_misalign is tied 0.

module instruction_fetch (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        bubble,
    output logic        fetch_misalign
);

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state;
    logic [31:0] fetch_pc;     // address of the next request to issue
    logic [31:0] resp_pc;      // PC belonging to the next kept response
    entry_t      fifo_mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  fifo_count;
    logic [1:0]  outstanding;  // accepted requests not yet answered
    logic [1:0]  drop_cnt;     // answers still owed to a discarded path

    logic [2:0]  credit;
    logic        accept;
    logic        resp;
    logic        drop;
    logic        keep;
    logic        pop;
    logic        bypass;
    logic        push;
    logic [31:0] target_pc;
    logic        target_misaligned;
    entry_t      head;

`ifdef IF_MISALIGN_TRAP_EN
    assign target_pc         = redirect_pc;
    assign target_misaligned = (redirect_pc[1:0] != 2'b00);
`else
    // Low address bits are meaningless without the trap; drop them.
    logic unused_pc_bits;
    assign unused_pc_bits    = ^redirect_pc[1:0];
    assign target_pc         = {redirect_pc[31:2], 2'b00};
    assign target_misaligned = 1'b0;
`endif

    assign imem_addr = fetch_pc;
    assign head      = fifo_mem[rd_ptr];

    // Request gating and per-cycle datapath events.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        credit   = {1'b0, fifo_count} + {1'b0, outstanding};
        imem_req = !reset && (state == FETCH) && !redirect && (credit < 3'd2);
        accept   = imem_req && imem_ready;
        // A strobe with nothing in flight belongs to a transfer abandoned by reset.
        resp     = imem_rvalid && (outstanding != 2'd0);
        drop     = resp && (drop_cnt != 2'd0);
        keep     = resp && !drop;
        pop      = !stall && (fifo_count != 2'd0);
        bypass   = keep && (fifo_count == 2'd0) && !stall;
        push     = keep && !bypass;
    end

    // FIFO storage; occupancy is tracked separately so the entries need no reset.
    // NOTE: the data array is deliberately left out of reset; fifo_count alone decides whether an entry is meaningful.
    always_ff @(posedge clock) begin
        if (push && !redirect) begin
            fifo_mem[wr_ptr] <= '{pc: resp_pc, instr: imem_rdata};
        end
    end

    // Fetch control, FIFO pointers, drop accounting and the output registers.
    // NOTE: all state here updates with <= so every branch reads the pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            outstanding <= 2'd0;
            drop_cnt    <= 2'd0;
            instr_out   <= NOP;
            pc_out      <= RESET_PC;
            bubble      <= 1'b1;
        end else begin
            outstanding <= outstanding + {1'b0, accept} - {1'b0, resp};
            if (redirect) begin
                // Everything in flight after this cycle belongs to the old path.
                state      <= target_misaligned ? HALT : FETCH;
                fetch_pc   <= target_pc;
                resp_pc    <= target_pc;
                rd_ptr     <= 1'b0;
                wr_ptr     <= 1'b0;
                fifo_count <= 2'd0;
                drop_cnt   <= outstanding - {1'b0, resp};
                instr_out  <= NOP;
                bubble     <= 1'b1;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (drop) begin
                    drop_cnt <= drop_cnt - 2'd1;
                end
                if (keep) begin
                    resp_pc <= resp_pc + 32'd4;
                end
                if (push) begin
                    wr_ptr <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
                if (!stall) begin
                    if (fifo_count != 2'd0) begin
                        instr_out <= head.instr;
                        pc_out    <= head.pc;
                        bubble    <= 1'b0;
                    end else if (bypass) begin
                        instr_out <= imem_rdata;
                        pc_out    <= resp_pc;
                        bubble    <= 1'b0;
                    end else begin
                        instr_out <= NOP;
                        bubble    <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    // Misalignment flag follows the most recent redirect target.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_misalign <= 1'b0;
        end else if (redirect) begin
            fetch_misalign <= target_misaligned;
        end
    end
`else
    assign fetch_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a table of per-cycle vectors from
// reset through streaming, stall, memory back-pressure and redirect, then
// hand-written sequences for redirect with two requests in flight, the
// misalignment trap, and reset with a request in flight. A memory model with
// configurable latency feeds a scoreboard of expected {pc, instr} outputs.

`timescale 1ns/1ps

module tb_instruction_fetch;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        bubble;
    logic        fetch_misalign;

    instruction_fetch dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_out      (instr_out),
        .pc_out         (pc_out),
        .bubble         (bubble),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Memory model: in-order, each accepted request answered 'mem_lat' cycles later.
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mem_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mem_t        mem_q[$];
    exp_t        exp_q[$];
    int          epoch     = 0;
    int          cyc       = 0;
    int          mem_lat   = 1;
    logic [31:0] exp_fetch = RESET_PC;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return ~a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] mask_target(input logic [31:0] a);
`ifdef IF_MISALIGN_TRAP_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    // One clock cycle: drive inputs, observe the request, clock, then score outputs.
    task automatic run_cycle(input logic s, input logic r, input logic [31:0] rpc, input logic rdy,
                             output logic req_seen, output logic [31:0] addr_seen);
        logic [31:0] prev_instr;
        logic [31:0] prev_pc;
        logic        prev_bubble;
        mem_t        m;
        exp_t        e;
        prev_instr  = instr_out;
        prev_pc     = pc_out;
        prev_bubble = bubble;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m           = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(m.addr);
            if (m.epoch == epoch && !r) begin
                exp_q.push_back('{pc: m.addr, instr: instr_of(m.addr)});
            end
        end
        #1;
        req_seen  = imem_req;
        addr_seen = imem_addr;
        if (r) check("req_low_on_redirect", 32'(imem_req), 32'd0);
        if (imem_req && imem_ready) begin
            check("fetch_addr", imem_addr, exp_fetch);
            mem_q.push_back('{addr: imem_addr, epoch: epoch, due: cyc + mem_lat});
            exp_fetch = exp_fetch + 32'd4;
        end
        if (r) begin
            epoch++;
            exp_fetch = mask_target(rpc);
        end
        @(posedge clock);
        cyc++;
        #1;
        if (r) begin
            check("redirect_bubble", 32'(bubble), 32'd1);
            check("redirect_nop", instr_out, NOP);
        end else if (s) begin
            check("stall_hold_instr", instr_out, prev_instr);
            check("stall_hold_pc", pc_out, prev_pc);
            check("stall_hold_bubble", 32'(bubble), 32'(prev_bubble));
        end else if (!bubble) begin
            if (exp_q.size() == 0) begin
                check("valid_without_expected_entry", 32'(bubble), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", pc_out, e.pc);
                check("sb_instr", instr_out, e.instr);
            end
        end else begin
            check("bubble_is_nop", instr_out, NOP);
        end
        @(negedge clock);
    endtask

    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input logic rdy);
        logic        q;
        logic [31:0] a;
        run_cycle(s, r, rpc, rdy, q, a);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        epoch++;
        exp_q.delete();
        exp_fetch = RESET_PC;
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pc_out", pc_out, RESET_PC);
        check("rst_instr", instr_out, NOP);
        check("rst_bubble", 32'(bubble), 32'd1);
        check("rst_misalign", 32'(fetch_misalign), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_held", 32'(imem_req), 32'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [31:0] rpc;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_bubble;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[18];

    initial begin
        logic        q;
        logic [31:0] a;
        bit          found;

        // stall redirect rpc ready | req addr (before edge) | bubble pc_out (after edge)
        vecs[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000};
        vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0004, 1'b0, 32'h0040_0000};
        vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0008, 1'b0, 32'h0040_0004};
        vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_000C, 1'b0, 32'h0040_0004};
        vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0004};
        vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0004};
        vecs[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0004};
        vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0040_0008};
        vecs[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0010, 1'b0, 32'h0040_000C};
        vecs[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0014, 1'b0, 32'h0040_0010};
        vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0018, 1'b0, 32'h0040_0014};
        vecs[11] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0014};
        vecs[12] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0014};
        vecs[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0018, 1'b1, 32'h0040_0014};
        vecs[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_001C, 1'b0, 32'h0040_0018};
        vecs[15] = '{1'b0, 1'b1, 32'h0040_0100, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0018};
        vecs[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0018};
        vecs[17] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0040_0104, 1'b0, 32'h0040_0100};

        do_reset();

        // Streaming, stall, back-pressure and a single-outstanding redirect.
        for (int i = 0; i < 18; i++) begin
            run_cycle(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].ready, q, a);
            check($sformatf("vec%0d_req", i), 32'(q), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), a, vecs[i].exp_addr);
            check($sformatf("vec%0d_bubble", i), 32'(bubble), 32'(vecs[i].exp_bubble));
            check($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
        end

        // Redirect while two requests are in flight: both answers must vanish.
        mem_lat = 3;
        found   = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (mem_q.size() == 2) found = 1'b1;
        end
        check("two_outstanding_reached", 32'(found), 32'd1);
        step(1'b0, 1'b1, 32'h0040_0100, 1'b1);
        mem_lat = 1;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b1);
            if (!bubble) found = 1'b1;
        end
        check("redirect2_valid_seen", 32'(found), 32'd1);
        check("redirect2_first_pc", pc_out, 32'h0040_0100);

        // Misaligned redirect.
`ifdef IF_MISALIGN_TRAP_EN
        step(1'b0, 1'b1, 32'h0040_0102, 1'b1);
        check("misalign_set", 32'(fetch_misalign), 32'd1);
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b0, 32'h0, 1'b1, q, a);
            check("halt_no_req", 32'(q), 32'd0);
            check("halt_bubble", 32'(bubble), 32'd1);
            check("halt_flag_held", 32'(fetch_misalign), 32'd1);
        end
        step(1'b0, 1'b1, 32'h0040_0200, 1'b1);
        check("misalign_cleared", 32'(fetch_misalign), 32'd0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, q, a);
        check("resume_req", 32'(q), 32'd1);
        check("resume_addr", a, 32'h0040_0200);
`else
        step(1'b0, 1'b1, 32'h0040_0102, 1'b1);
        check("misalign_tied_low", 32'(fetch_misalign), 32'd0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, q, a);
        check("aligned_req", 32'(q), 32'd1);
        check("aligned_addr", a, 32'h0040_0100);
`endif
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset with one request in flight; its late answer must be ignored.
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, q, a);
        check("pre_reset_accept", 32'(q && imem_ready), 32'd1);
        do_reset();
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, q, a);
        check("post_reset_addr", a, RESET_PC);
        check("post_reset_stale_ignored", 32'(bubble), 32'd1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("post_reset_first_pc", pc_out, RESET_PC);
        check("post_reset_first_valid", 32'(bubble), 32'd0);

        // Drain with no new acceptances: nothing lost, nothing duplicated.
        for (int i = 0; i < 20 && (exp_q.size() != 0 || mem_q.size() != 0); i++) begin
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 1'b0, 32'h0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("memory_drained", 32'(mem_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
